// File: rtl/junction_dose_sequencer.sv
// junction_dose_sequencer
// Meters solution 1 and solution 2 into a two-inlet diffusion mixer together, each inlet valve
// open for its own programmed number of cycles. The outlet valve stays open until both inlets
// have closed and a transit/flush interval has elapsed. Completion is then reported with a
// one-cycle done pulse. Each accepted start produces exactly one dose.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          request one dose (sampled only while idle)
//   abort          synchronous abort of a running dose
//   dose1_cycles   solution-1 inlet open time in cycles
//   dose2_cycles   solution-2 inlet open time in cycles
//   settle_cycles  transit time in cycles after both inlets close
//   valve_soln1    solution-1 inlet valve open
//   valve_soln2    solution-2 inlet valve open
//   valve_out      outlet valve open
//   busy           dose in progress
//   done           one-cycle pulse on normal completion
//   aborted        one-cycle pulse on abort
module junction_dose_sequencer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] dose1_cycles,
  input  logic [CNT_W-1:0] dose2_cycles,
  input  logic [CNT_W-1:0] settle_cycles,
  output logic             valve_soln1,
  output logic             valve_soln2,
  output logic             valve_out,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StInject  = 2'd1;
  localparam logic [1:0] StTransit = 2'd2;
  localparam logic [1:0] StFinish  = 2'd3;

  logic [1:0]       state_q, state_d;
  // cnt_q holds the 1-based index of the current cycle within INJECT or TRANSIT.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] d1_q, d1_d, d2_q, d2_d, m_q, m_d, s_q, s_d;
  logic             v1_q, v1_d, v2_q, v2_d, vout_q, vout_d;
  logic             busy_q, busy_d, done_q, done_d, abt_q, abt_d;
  logic [CNT_W-1:0] dose_max;

  assign dose_max = (dose1_cycles >= dose2_cycles) ? dose1_cycles : dose2_cycles;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    m_d     = m_q;
    s_d     = s_q;
    v1_d    = 1'b0;
    v2_d    = 1'b0;
    vout_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    abt_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          d1_d = dose1_cycles;
          d2_d = dose2_cycles;
          s_d  = settle_cycles;
          m_d  = dose_max;
          if (dose_max != '0) begin
            state_d = StInject;
            cnt_d   = CNT_W'(1);
            v1_d    = (dose1_cycles != '0);
            v2_d    = (dose2_cycles != '0);
            vout_d  = 1'b1;
            busy_d  = 1'b1;
          end else if (settle_cycles != '0) begin
            state_d = StTransit;
            cnt_d   = CNT_W'(1);
            vout_d  = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = StFinish;
            done_d  = 1'b1;
          end
        end
      end
      StInject: begin
        if (abort) begin
          state_d = StIdle;
          cnt_d   = '0;
          abt_d   = 1'b1;
        end else if (cnt_q == m_q) begin
          if (s_q != '0) begin
            state_d = StTransit;
            cnt_d   = CNT_W'(1);
            vout_d  = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = StFinish;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          // Next cycle index is cnt_q+1; valve stays open while that index <= dose.
          cnt_d  = cnt_q + CNT_W'(1);
          v1_d   = (cnt_q < d1_q);
          v2_d   = (cnt_q < d2_q);
          vout_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      StTransit: begin
        if (abort) begin
          state_d = StIdle;
          cnt_d   = '0;
          abt_d   = 1'b1;
        end else if (cnt_q == s_q) begin
          state_d = StFinish;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          vout_d = 1'b1;
          busy_d = 1'b1;
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      m_q     <= '0;
      s_q     <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      vout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      m_q     <= m_d;
      s_q     <= s_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      vout_q  <= vout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abt_q   <= abt_d;
    end
  end

  assign valve_soln1 = v1_q;
  assign valve_soln2 = v2_q;
  assign valve_out   = vout_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = abt_q;

endmodule

// File: tb/tb_junction_dose_sequencer.sv
// Directed bench for junction_dose_sequencer with a cycle-index reference model and
// literal spot checks taken from hand-worked timelines.
module tb_junction_dose_sequencer;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] dose1 = '0, dose2 = '0, settle = '0;
  logic         v1, v2, vo, bz, dn, ab;

  int n_cmp = 0;
  int n_err = 0;
  int cn = 0;

  junction_dose_sequencer #(.CNT_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .dose1_cycles (dose1),
    .dose2_cycles (dose2),
    .settle_cycles(settle),
    .valve_soln1  (v1),
    .valve_soln2  (v2),
    .valve_out    (vo),
    .busy         (bz),
    .done         (dn),
    .aborted      (ab)
  );

  always #5 clk = ~clk;

  // Reference model: cycle index within the running dose (1 = first cycle after start edge).
  // Dose of length T = max(D1,D2)+S occupies indices 1..T, done at index T+1.
  bit m_run = 1'b0;
  bit m_ab = 1'b0;
  int m_cur = 0, m_d1 = 0, m_d2 = 0, m_t = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0;
      m_ab  <= 1'b0;
      m_cur <= 0;
    end else begin
      m_ab <= 1'b0;
      if (m_run) begin
        if (m_cur <= m_t && abort) begin
          m_run <= 1'b0;
          m_ab  <= 1'b1;
        end else if (m_cur == m_t + 1) begin
          m_run <= 1'b0;
        end else begin
          m_cur <= m_cur + 1;
        end
      end else if (start && !abort) begin
        m_d1  <= int'(dose1);
        m_d2  <= int'(dose2);
        m_t   <= ((dose1 > dose2) ? int'(dose1) : int'(dose2)) + int'(settle);
        m_cur <= 1;
        m_run <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (t=%0t cn=%0d)", nm, act, exp, $time, cn);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_v1", v1, m_run && m_cur <= m_d1);
    chk("model_v2", v2, m_run && m_cur <= m_d2);
    chk("model_vout", vo, m_run && m_cur <= m_t);
    chk("model_busy", bz, m_run && m_cur <= m_t);
    chk("model_done", dn, m_run && m_cur == m_t + 1);
    chk("model_aborted", ab, m_ab);
    if ((v1 || v2) && !vo) chk("interlock", vo, 1'b1);
  end

  task automatic step();
    @(negedge clk);
    cn++;
  endtask

  task automatic launch(input int a, input int b, input int s);
    dose1  = W'(a);
    dose2  = W'(b);
    settle = W'(s);
    start  = 1'b1;
    cn     = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_busy", bz, 1'b0);
    chk("reset_vout", vo, 1'b0);
    step();

    // D1=3 D2=5 S=4
    launch(3, 5, 4);
    step(); start = 1'b0;
    chk("t1_v1_c1", v1, 1'b1); chk("t1_v2_c1", v2, 1'b1); chk("t1_busy_c1", bz, 1'b1);
    step(); step(); chk("t1_v1_c3", v1, 1'b1);
    step(); chk("t1_v1_c4", v1, 1'b0); chk("t1_v2_c4", v2, 1'b1);
    step(); chk("t1_v2_c5", v2, 1'b1);
    step(); chk("t1_v2_c6", v2, 1'b0); chk("t1_vout_c6", vo, 1'b1);
    repeat (3) step();
    chk("t1_busy_c9", bz, 1'b1); chk("t1_vout_c9", vo, 1'b1); chk("t1_done_c9", dn, 1'b0);
    step(); chk("t1_done_c10", dn, 1'b1); chk("t1_busy_c10", bz, 1'b0); chk("t1_vout_c10", vo, 1'b0);
    step(); chk("t1_done_c11", dn, 1'b0);

    // D1=0 D2=2 S=0
    launch(0, 2, 0);
    step(); start = 1'b0;
    chk("t2_v1_c1", v1, 1'b0); chk("t2_v2_c1", v2, 1'b1); chk("t2_vout_c1", vo, 1'b1);
    step(); chk("t2_v2_c2", v2, 1'b1);
    step(); chk("t2_done_c3", dn, 1'b1); chk("t2_v2_c3", v2, 1'b0);
    step();

    // All zero
    launch(0, 0, 0);
    step(); start = 1'b0;
    chk("t3_done_c1", dn, 1'b1); chk("t3_busy_c1", bz, 1'b0); chk("t3_vout_c1", vo, 1'b0);
    step(); chk("t3_done_c2", dn, 1'b0);
    step();

    // Abort at edge 6 of a 10/10/10 run, fresh start at edge 8
    launch(10, 10, 10);
    step(); start = 1'b0;
    repeat (5) step();
    abort = 1'b1;
    step(); abort = 1'b0;
    chk("t4_ab_c7", ab, 1'b1); chk("t4_v1_c7", v1, 1'b0); chk("t4_v2_c7", v2, 1'b0);
    chk("t4_vout_c7", vo, 1'b0); chk("t4_busy_c7", bz, 1'b0); chk("t4_done_c7", dn, 1'b0);
    step(); chk("t4_ab_c8", ab, 1'b0);
    dose1 = W'(1); dose2 = W'(1); settle = '0; start = 1'b1;
    step(); start = 1'b0; chk("t4_v1_c9", v1, 1'b1); chk("t4_busy_c9", bz, 1'b1);
    step(); chk("t4_done_c10", dn, 1'b1);
    step();

    // Config change and start pulse during INJECT are ignored
    launch(4, 4, 2);
    step(); start = 1'b0;
    step(); dose1 = W'(9); dose2 = W'(9); settle = W'(9); start = 1'b1;
    step(); start = 1'b0;
    repeat (3) step();
    chk("t5_busy_c6", bz, 1'b1); chk("t5_v1_c6", v1, 1'b0);
    step(); chk("t5_done_c7", dn, 1'b1);
    repeat (5) step(); chk("t5_busy_c12", bz, 1'b0);

    // abort with start in the same idle cycle
    abort = 1'b1; start = 1'b1;
    step(); abort = 1'b0; start = 1'b0;
    chk("t6_busy", bz, 1'b0); chk("t6_ab", ab, 1'b0);
    step();

    // abort during FINISH is ignored
    launch(2, 0, 0);
    step(); start = 1'b0;
    step(); step(); chk("t7_done_c3", dn, 1'b1);
    abort = 1'b1;
    step(); abort = 1'b0; chk("t7_ab_c4", ab, 1'b0);
    step();

    // start held high: back-to-back with one idle cycle
    launch(1, 0, 0);
    step(); chk("t8_busy_c1", bz, 1'b1);
    step(); chk("t8_done_c2", dn, 1'b1);
    step(); chk("t8_busy_c3", bz, 1'b0);
    step(); chk("t8_busy_c4", bz, 1'b1); start = 1'b0;
    step(); chk("t8_done_c5", dn, 1'b1);
    step();

    // asynchronous reset mid-TRANSIT
    launch(2, 2, 5);
    step(); start = 1'b0;
    repeat (3) step();
    chk("t9_vout_pre", vo, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("t9_rst_v1", v1, 1'b0); chk("t9_rst_v2", v2, 1'b0); chk("t9_rst_vout", vo, 1'b0);
    chk("t9_rst_busy", bz, 1'b0); chk("t9_rst_done", dn, 1'b0); chk("t9_rst_ab", ab, 1'b0);
    step(); step();
    rst_n = 1'b1;
    step();
    abort = 1'b1;
    step(); abort = 1'b0;
    chk("t9_idle_abort", ab, 1'b0);
    launch(1, 0, 1);
    step(); start = 1'b0; chk("t9_v1_c1", v1, 1'b1);
    step(); chk("t9_v1_c2", v1, 1'b0); chk("t9_vout_c2", vo, 1'b1);
    step(); chk("t9_done_c3", dn, 1'b1);
    step();

    // maximum dose runs to completion exactly
    launch(65535, 1, 1);
    step(); start = 1'b0;
    step(); chk("t10_v2_c2", v2, 1'b0); chk("t10_v1_c2", v1, 1'b1);
    while (dn !== 1'b1 && cn < 70000) step();
    chk_int("t10_done_cycle", cn, 65537);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
